stage_mem: RTL

Memory-access stage directly downstream of the execute stage. It consumes the EX/MEM pipeline register contents and performs word loads and stores over the shared bus through a request/grant/ready handshake. It raises a busy signal so the pipeline controller stalls while an access is in flight. It then updates the MEM/WB pipeline register with the load data or the pass-through execute result.

---
 rtl/stage_mem_pkg.sv | 46 ++++
 rtl/stage_mem_if.sv | 24 ++
 rtl/stage_mem_bus_if.sv | 92 +++++++++
 rtl/stage_mem.sv | 107 ++++++++++
 4 files changed

// File: rtl/stage_mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
// Holds mem-op and exception encodings, bus FSM states and the MEM/WB record.
package stage_mem_pkg;

    localparam int WORD_W  = 32;
    localparam int WADDR_W = 30;

    typedef enum logic [1:0] {
        MEM_OP_NONE  = 2'd0,
        MEM_OP_LOAD  = 2'd1,
        MEM_OP_STORE = 2'd2
    } mem_op_e;

    localparam logic [2:0] EXP_NONE          = 3'd0;
    localparam logic [2:0] EXP_INT           = 3'd1;
    localparam logic [2:0] EXP_OVF           = 3'd3;
    localparam logic [2:0] EXP_CODE_MISALIGN = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_HOLD   = 2'd3
    } bus_state_e;

    typedef struct packed {
        logic [WADDR_W-1:0] pc;
        logic               en;
        logic               br_flag;
        logic [1:0]         ctrl_op;
        logic [4:0]         dst_addr;
        logic               gpr_we_;
        logic [2:0]         exp_code;
        logic [WORD_W-1:0]  out;
    } memwb_t;

    // Op code 3 is reserved and behaves like "no memory access".
    function automatic logic is_mem_op(input logic [1:0] op);
        return (op == MEM_OP_LOAD) || (op == MEM_OP_STORE);
    endfunction

    function automatic logic [WADDR_W-1:0] word_addr(input logic [WORD_W-1:0] byte_addr);
        return byte_addr[WORD_W-1:2];
    endfunction

endpackage

// File: rtl/stage_mem_if.sv
// Shared-bus request/grant/ready handshake between the MEM stage and the bus.
interface stage_mem_if;
    import stage_mem_pkg::*;

    logic               bus_req;
    logic               bus_grant;
    logic               bus_as;
    logic               bus_rw;
    logic [WADDR_W-1:0] bus_addr;
    logic [WORD_W-1:0]  bus_wr_data;
    logic [WORD_W-1:0]  bus_rd_data;
    logic               bus_rdy;

    modport master (
        output bus_req, bus_as, bus_rw, bus_addr, bus_wr_data,
        input  bus_grant, bus_rd_data, bus_rdy
    );

    modport slave (
        input  bus_req, bus_as, bus_rw, bus_addr, bus_wr_data,
        output bus_grant, bus_rd_data, bus_rdy
    );

endinterface

// File: rtl/stage_mem_bus_if.sv
// Bus access sequencer: request/grant/ready FSM with registered bus outputs,
// a read-data buffer for stalled completions, and the stage busy signal.
module mem_bus_if
    import stage_mem_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               stall,
    input  logic               flush,
    input  logic               access_req,
    input  logic               is_load,
    input  logic [WADDR_W-1:0] word_addr_in,
    input  logic [WORD_W-1:0]  wr_data_in,
    stage_mem_if.master        bus,
    output logic               mem_busy,
    output logic [WORD_W-1:0]  rd_data
);

    bus_state_e         state_reg;
    logic               req_reg;
    logic               as_reg;
    logic               rw_reg;
    logic [WADDR_W-1:0] addr_reg;
    logic [WORD_W-1:0]  wr_data_reg;
    logic [WORD_W-1:0]  rd_buf_reg;
    logic               rdy_now;

    assign rdy_now = (state_reg == ST_ACCESS) && bus.bus_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg   <= ST_IDLE;
            req_reg     <= 1'b0;
            as_reg      <= 1'b0;
            rw_reg      <= 1'b1;
            addr_reg    <= '0;
            wr_data_reg <= '0;
            rd_buf_reg  <= '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (access_req && !flush) begin
                        state_reg <= ST_REQ;
                        req_reg   <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (flush) begin
                        state_reg <= ST_IDLE;
                        req_reg   <= 1'b0;
                    end else if (bus.bus_grant) begin
                        // EX/MEM is frozen by mem_busy, so latching here is safe.
                        state_reg   <= ST_ACCESS;
                        as_reg      <= 1'b1;
                        rw_reg      <= is_load;
                        addr_reg    <= word_addr_in;
                        wr_data_reg <= wr_data_in;
                    end
                end
                ST_ACCESS: begin
                    // Flush does not abort a granted access; the bus cycle must finish.
                    if (bus.bus_rdy) begin
                        rd_buf_reg <= bus.bus_rd_data;
                        req_reg    <= 1'b0;
                        as_reg     <= 1'b0;
                        rw_reg     <= 1'b1;
                        state_reg  <= stall ? ST_HOLD : ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!stall) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign mem_busy = ((state_reg == ST_IDLE) && access_req)
                    || (state_reg == ST_REQ)
                    || ((state_reg == ST_ACCESS) && !bus.bus_rdy);

    assign rd_data = rdy_now ? bus.bus_rd_data : rd_buf_reg;

    assign bus.bus_req     = req_reg;
    assign bus.bus_as      = as_reg;
    assign bus.bus_rw      = rw_reg;
    assign bus.bus_addr    = addr_reg;
    assign bus.bus_wr_data = wr_data_reg;

endmodule

// File: rtl/stage_mem.sv
// Memory-access pipeline stage: drives word loads/stores on the shared bus and
// updates the MEM/WB register with load data or the pass-through EX result.
module stage_mem
    import stage_mem_pkg::*;
#(
    parameter int         DATA_W       = WORD_W,
    parameter int         ADDR_W       = WADDR_W,
    parameter logic [2:0] EXP_MISALIGN = EXP_CODE_MISALIGN
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] ex_pc,
    input  logic              ex_en,
    input  logic              ex_br_flag,
    input  logic [1:0]        ex_mem_op,
    input  logic [DATA_W-1:0] ex_mem_wr_data,
    input  logic [1:0]        ex_ctrl_op,
    input  logic [4:0]        ex_dst_addr,
    input  logic              ex_gpr_we_,
    input  logic [2:0]        ex_exp_code,
    input  logic [DATA_W-1:0] ex_out,
    stage_mem_if.master       bus,
    output logic              mem_busy,
    output logic [DATA_W-1:0] fwd_data,
    output logic [ADDR_W-1:0] mem_pc,
    output logic              mem_en,
    output logic              mem_br_flag,
    output logic [1:0]        mem_ctrl_op,
    output logic [4:0]        mem_dst_addr,
    output logic              mem_gpr_we_,
    output logic [2:0]        mem_exp_code,
    output logic [DATA_W-1:0] mem_out
);

    logic              mem_inst;
    logic              aligned;
    logic              access_req;
    logic              misalign;
    logic              is_load;
    logic [WORD_W-1:0] rd_data;
    memwb_t            wb_reg;
    memwb_t            wb_next;

    // Only a valid, exception-free load/store touches memory.
    assign mem_inst   = ex_en && (ex_exp_code == EXP_NONE) && is_mem_op(ex_mem_op);
    assign aligned    = (ex_out[1:0] == 2'b00);
    assign access_req = mem_inst && aligned;
    assign misalign   = mem_inst && !aligned;
    assign is_load    = (ex_mem_op == MEM_OP_LOAD);

    mem_bus_if u_bus (
        .clk          (clk),
        .rst          (rst),
        .stall        (stall),
        .flush        (flush),
        .access_req   (access_req),
        .is_load      (is_load),
        .word_addr_in (word_addr(ex_out)),
        .wr_data_in   (ex_mem_wr_data),
        .bus          (bus),
        .mem_busy     (mem_busy),
        .rd_data      (rd_data)
    );

    always_comb begin
        wb_next.pc       = ex_pc;
        wb_next.en       = ex_en;
        wb_next.br_flag  = ex_br_flag;
        wb_next.ctrl_op  = ex_ctrl_op;
        wb_next.dst_addr = ex_dst_addr;
        wb_next.gpr_we_  = ex_gpr_we_;
        wb_next.exp_code = ex_exp_code;
        wb_next.out      = (access_req && is_load) ? rd_data : ex_out;
        if (flush) begin
            wb_next         = '0;
            wb_next.gpr_we_ = 1'b1;
        end else if (misalign) begin
            wb_next.exp_code = EXP_MISALIGN;
            wb_next.gpr_we_  = 1'b1;
            wb_next.ctrl_op  = 2'b00;
            wb_next.dst_addr = 5'd0;
            wb_next.out      = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_reg         <= '0;
            wb_reg.gpr_we_ <= 1'b1;
        end else if (!stall) begin
            wb_reg <= wb_next;
        end
    end

    assign fwd_data     = wb_next.out;
    assign mem_pc       = wb_reg.pc;
    assign mem_en       = wb_reg.en;
    assign mem_br_flag  = wb_reg.br_flag;
    assign mem_ctrl_op  = wb_reg.ctrl_op;
    assign mem_dst_addr = wb_reg.dst_addr;
    assign mem_gpr_we_  = wb_reg.gpr_we_;
    assign mem_exp_code = wb_reg.exp_code;
    assign mem_out      = wb_reg.out;

endmodule
